// File: rtl/pwm_multi_pkg.sv
// pwm_multi_pkg: shared types and constants for the multi-channel PWM block.
//   TW        : width of every time quantity (dt, period, on, phase, acc)
//   DEF_N_CH  : default channel count used by the top level
//   CH_BITS   : channel-select width for the default channel count
//   time_t    : unsigned time in emulator LSBs
//   chan_cfg_t: one channel's configuration {en, period, on, phase}
package pwm_multi_pkg;

    localparam int TW       = 24;
    localparam int DEF_N_CH = 4;
    localparam int CH_BITS  = (DEF_N_CH > 1) ? $clog2(DEF_N_CH) : 1;

    typedef logic [TW-1:0] time_t;

    typedef struct packed {
        logic  en;
        time_t period;
        time_t on;
        time_t phase;
    } chan_cfg_t;

    // A channel only runs when enabled with a non-zero period.
    function automatic logic chan_live(input chan_cfg_t c);
        return c.en && (c.period != {TW{1'b0}});
    endfunction

endpackage

// File: rtl/pwm_multi_chan.sv
// pwm_chan: one PWM channel with shadowed configuration.
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_cke, i_dt, i_sync : step enable, per-step increment, resync pulse
//   i_wr                : accepted configuration write for this channel
//   i_cfg_*             : configuration payload of that write
//   o_pend              : shadow holds a write not yet applied
//   o_out, o_wrap       : registered PWM output and one-cycle wrap pulse
module pwm_chan
    import pwm_multi_pkg::*;
#(
    parameter int DEF_PERIOD = 1000
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_cke,
    input  logic [TW-1:0] i_dt,
    input  logic          i_sync,
    input  logic          i_wr,
    input  logic          i_cfg_en,
    input  logic [TW-1:0] i_cfg_period,
    input  logic [TW-1:0] i_cfg_on,
    input  logic [TW-1:0] i_cfg_phase,
    output logic          o_pend,
    output logic          o_out,
    output logic          o_wrap
);

    localparam chan_cfg_t RST_CFG = '{en: 1'b0, period: time_t'(DEF_PERIOD),
                                      on: {TW{1'b0}}, phase: {TW{1'b0}}};

    chan_cfg_t r_act;
    chan_cfg_t r_shd;
    logic      r_pend;
    time_t     r_acc;
    logic      r_out;
    logic      r_wrap;

    chan_cfg_t     w_act_nxt;
    time_t         w_acc_nxt;
    logic [TW:0]   w_sum;
    logic [TW:0]   w_rem;
    logic          w_live_cur;
    logic          w_live_nxt;
    logic          w_wrap;
    logic          w_apply;

    // Next-state: wrap detection, shadow apply, accumulator update.
    always_comb begin
        w_live_cur = chan_live(r_act);
        w_sum      = {1'b0, r_acc} + {1'b0, i_dt};
        w_rem      = w_sum - {1'b0, r_act.period};
        // Wrap is judged against the config that was active during the step;
        // a sync replaces the step, so it never wraps.
        w_wrap     = i_cke && !i_sync && w_live_cur && (w_sum >= {1'b0, r_act.period});
        w_apply    = r_pend && (!w_live_cur || w_wrap);
        w_act_nxt  = w_apply ? r_shd : r_act;
        w_live_nxt = chan_live(w_act_nxt);

        if (!w_live_nxt || !w_live_cur) begin
            // Idle channels park at their phase, which also seeds a fresh enable.
            w_acc_nxt = w_act_nxt.phase;
        end else if (i_cke && i_sync) begin
            w_acc_nxt = w_act_nxt.phase;
        end else if (w_wrap) begin
            // An increment of more than a whole period restarts the cycle.
            if (w_rem >= {1'b0, r_act.period}) begin
                w_acc_nxt = {TW{1'b0}};
            end else begin
                w_acc_nxt = w_rem[TW-1:0];
            end
        end else if (i_cke) begin
            w_acc_nxt = w_sum[TW-1:0];
        end else begin
            w_acc_nxt = r_acc;
        end
    end

    // Channel state registers and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_act  <= RST_CFG;
            r_shd  <= RST_CFG;
            r_pend <= 1'b0;
            r_acc  <= {TW{1'b0}};
            r_out  <= 1'b0;
            r_wrap <= 1'b0;
        end else begin
            r_act <= w_act_nxt;
            // A write is only accepted while nothing is pending, so it never
            // collides with an apply.
            if (i_wr) begin
                r_shd  <= '{en: i_cfg_en, period: i_cfg_period,
                            on: i_cfg_on, phase: i_cfg_phase};
                r_pend <= 1'b1;
            end else if (w_apply) begin
                r_pend <= 1'b0;
            end else begin
                r_pend <= r_pend;
            end
            r_acc  <= w_acc_nxt;
            r_out  <= w_live_nxt && (w_acc_nxt < w_act_nxt.on);
            r_wrap <= w_wrap;
        end
    end

    assign o_pend = r_pend;
    assign o_out  = r_out;
    assign o_wrap = r_wrap;

endmodule

// File: rtl/pwm_multi.sv
// pwm_multi: N-channel PWM generator with programmable period/on/phase.
//   i_clk, i_rst         : clock, synchronous active-high reset
//   i_cke, i_dt          : emulator step enable and time increment
//   i_sync               : global resync of all running channels to phase
//   i_cfg_valid/o_cfg_ready, i_cfg_ch, i_cfg_en/period/on/phase
//                        : configuration write handshake
//   o_out, o_wrap        : per-channel PWM output and period-wrap pulse
module pwm_multi
    import pwm_multi_pkg::*;
#(
    parameter  int N_CH       = DEF_N_CH,
    parameter  int DEF_PERIOD = 1000,
    localparam int CW         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_cke,
    input  logic [TW-1:0]   i_dt,
    input  logic            i_sync,
    input  logic            i_cfg_valid,
    output logic            o_cfg_ready,
    input  logic [CW-1:0]   i_cfg_ch,
    input  logic            i_cfg_en,
    input  logic [TW-1:0]   i_cfg_period,
    input  logic [TW-1:0]   i_cfg_on,
    input  logic [TW-1:0]   i_cfg_phase,
    output logic [N_CH-1:0] o_out,
    output logic [N_CH-1:0] o_wrap
);

    logic [N_CH-1:0] w_pend;
    logic [N_CH-1:0] w_wr;
    logic            w_ch_ok;

    // Handshake: ready tracks the addressed channel's pending bit; writes to
    // a channel that does not exist are accepted and dropped.
    always_comb begin
        w_ch_ok     = (int'(i_cfg_ch) < N_CH);
        o_cfg_ready = w_ch_ok ? !w_pend[i_cfg_ch] : 1'b1;
        for (int c = 0; c < N_CH; c++) begin
            w_wr[c] = i_cfg_valid && o_cfg_ready && (int'(i_cfg_ch) == c);
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        pwm_chan #(
            .DEF_PERIOD (DEF_PERIOD)
        ) u_chan (
            .i_clk        (i_clk),
            .i_rst        (i_rst),
            .i_cke        (i_cke),
            .i_dt         (i_dt),
            .i_sync       (i_sync),
            .i_wr         (w_wr[g]),
            .i_cfg_en     (i_cfg_en),
            .i_cfg_period (i_cfg_period),
            .i_cfg_on     (i_cfg_on),
            .i_cfg_phase  (i_cfg_phase),
            .o_pend       (w_pend[g]),
            .o_out        (o_out[g]),
            .o_wrap       (o_wrap[g])
        );
    end

endmodule
